// File: rtl/ex_mem_stage_if.sv
// EX->MEM payload bundle with a valid/ready handshake; the master drives
// valid and the payload, the slave drives ready.
interface ex_mem_stage_if #(
  parameter int XLEN = 64
);
  logic            valid;
  logic            ready;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] dmem_write_data;
  logic            is_write_dmem;
  logic [1:0]      wb_select;
  logic [7:0]      write_width;
  logic            word_op;
  logic [4:0]      rd;
  logic            reg_write;

  modport master (
    output valid, alu_result, dmem_write_data, is_write_dmem, wb_select,
           write_width, word_op, rd, reg_write,
    input  ready
  );

  modport slave (
    input  valid, alu_result, dmem_write_data, is_write_dmem, wb_select,
           write_width, word_op, rd, reg_write,
    output ready
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with a 2-entry skid buffer (registered ex.ready),
// synchronous flush and a saturating stall-cycle counter.
module ex_mem_stage #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             flush,
  ex_mem_stage_if.slave    ex,
  ex_mem_stage_if.master   mem,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] dmem_write_data;
    logic            is_write_dmem;
    logic [1:0]      wb_select;
    logic [7:0]      write_width;
    logic            word_op;
    logic [4:0]      rd;
    logic            reg_write;
  } payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t   state, state_nxt;
  payload_t in_pl;
  payload_t main_p1, skid_p1;
  payload_t main_nxt, skid_nxt;
  logic     in_fire, out_fire;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign in_pl = '{
    alu_result:      ex.alu_result,
    dmem_write_data: ex.dmem_write_data,
    is_write_dmem:   ex.is_write_dmem,
    wb_select:       ex.wb_select,
    write_width:     ex.write_width,
    word_op:         ex.word_op,
    rd:              ex.rd,
    reg_write:       ex.reg_write
  };

  // Both handshake outputs decode the state register only, so mem.ready
  // never reaches ex.ready combinationally.
  assign ex.ready  = (state != FULL);
  assign mem.valid = (state != EMPTY);

  assign in_fire  = ex.valid & ex.ready;
  assign out_fire = mem.valid & mem.ready;

  always_comb begin
    state_nxt = state;
    main_nxt  = main_p1;
    skid_nxt  = skid_p1;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state_nxt = BUSY;
            main_nxt  = in_pl;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_nxt = in_pl;
          end else if (out_fire) begin
            state_nxt = EMPTY;
          end else if (in_fire) begin
            state_nxt = FULL;
            skid_nxt  = in_pl;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_nxt = BUSY;
            main_nxt  = skid_p1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Stage p1: main/skid registers and stall counter
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state     <= EMPTY;
      main_p1   <= '0;
      skid_p1   <= '0;
      stall_cnt <= '0;
    end else begin
      state   <= state_nxt;
      main_p1 <= main_nxt;
      skid_p1 <= skid_nxt;
      if (mem.valid && !mem.ready) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
    end
  end

  assign mem.alu_result      = main_p1.alu_result;
  assign mem.dmem_write_data = main_p1.dmem_write_data;
  assign mem.is_write_dmem   = main_p1.is_write_dmem;
  assign mem.wb_select       = main_p1.wb_select;
  assign mem.write_width     = main_p1.write_width;
  assign mem.word_op         = main_p1.word_op;
  assign mem.rd              = main_p1.rd;
  assign mem.reg_write       = main_p1.reg_write;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: accepted payloads queue up as expected
// output, a monitor pops them in order whenever MEM consumes one.
module tb_ex_mem_stage;
  localparam int XLEN = 64;

  typedef struct packed {
    logic [63:0] alu_result;
    logic [63:0] dmem_write_data;
    logic        is_write_dmem;
    logic [1:0]  wb_select;
    logic [7:0]  write_width;
    logic        word_op;
    logic [4:0]  rd;
    logic        reg_write;
  } pl_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        flush   = 1'b0;
  logic [31:0] stall_cnt;
  logic [3:0]  stall_cnt4;

  ex_mem_stage_if #(.XLEN(XLEN)) ex ();
  ex_mem_stage_if #(.XLEN(XLEN)) mem ();
  ex_mem_stage_if #(.XLEN(XLEN)) ex4 ();
  ex_mem_stage_if #(.XLEN(XLEN)) mem4 ();

  ex_mem_stage #(.XLEN(XLEN), .CNT_W(32)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .flush(flush),
    .ex(ex), .mem(mem), .stall_cnt(stall_cnt)
  );

  // Narrow-counter copy sees the same traffic; only its counter is checked.
  ex_mem_stage #(.XLEN(XLEN), .CNT_W(4)) dut4 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .flush(flush),
    .ex(ex4), .mem(mem4), .stall_cnt(stall_cnt4)
  );

  assign ex4.valid           = ex.valid;
  assign ex4.alu_result      = ex.alu_result;
  assign ex4.dmem_write_data = ex.dmem_write_data;
  assign ex4.is_write_dmem   = ex.is_write_dmem;
  assign ex4.wb_select       = ex.wb_select;
  assign ex4.write_width     = ex.write_width;
  assign ex4.word_op         = ex.word_op;
  assign ex4.rd              = ex.rd;
  assign ex4.reg_write       = ex.reg_write;
  assign mem4.ready          = mem.ready;

  always #5 sys_clk = ~sys_clk;

  pl_t q[$];
  int  total = 0;
  int  bad   = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic pl_t mem_pl();
    return '{mem.alu_result, mem.dmem_write_data, mem.is_write_dmem, mem.wb_select,
             mem.write_width, mem.word_op, mem.rd, mem.reg_write};
  endfunction

  function automatic pl_t ex_pl();
    return '{ex.alu_result, ex.dmem_write_data, ex.is_write_dmem, ex.wb_select,
             ex.write_width, ex.word_op, ex.rd, ex.reg_write};
  endfunction

  task automatic drive(input logic v, input logic [63:0] alu);
    ex.valid           = v;
    ex.alu_result      = alu;
    ex.dmem_write_data = {$urandom, $urandom};
    ex.is_write_dmem   = 1'($urandom);
    ex.wb_select       = 2'($urandom);
    ex.write_width     = 8'($urandom);
    ex.word_op         = 1'($urandom);
    ex.rd              = 5'($urandom);
    ex.reg_write       = 1'($urandom);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Reference model: an ordered queue of accepted payloads; flush or reset empties it.
  always @(negedge sys_clk or negedge sys_rst) begin
    if (!sys_rst)
      q.delete();
    else if (flush)
      q.delete();
    else if (ex.valid && ex.ready)
      q.push_back(ex_pl());
  end

  pl_t held;
  bit  stalled = 1'b0;

  always @(negedge sys_clk) begin
    if (!sys_rst || flush) begin
      stalled <= 1'b0;
    end else begin
      if (stalled && mem.valid)
        check("hold_stable", mem_pl(), held);
      if (mem.valid && mem.ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got alu=%h expected no output", mem.alu_result);
        end else begin
          check("fifo_order", mem_pl(), q.pop_front());
        end
      end
      stalled <= mem.valid && !mem.ready;
      held    <= mem_pl();
    end
  end

  initial begin
    drive(1'b0, 64'd0);
    mem.ready = 1'b0;
    sys_rst   = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    check("rst_mem_valid", mem.valid, 1'b0);
    check("rst_ex_ready", ex.ready, 1'b1);
    check("rst_stall_cnt", stall_cnt, 32'd0);
    check("rst_alu", mem.alu_result, 64'd0);
    #2 sys_rst = 1'b1;

    // Streaming with 1-cycle latency
    mem.ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 64'(i));
      tick();
      check("stream_valid", mem.valid, 1'b1);
      check("stream_alu", mem.alu_result, 64'(i));
    end
    drive(1'b0, 64'd0);
    tick();
    check("stream_drained", mem.valid, 1'b0);

    // Backpressure into the skid buffer
    mem.ready = 1'b0;
    drive(1'b1, 64'h11);
    tick();
    check("bp_busy_ready", ex.ready, 1'b1);
    drive(1'b1, 64'h22);
    tick();
    check("bp_full_ready", ex.ready, 1'b0);
    check("bp_head_a", mem.alu_result, 64'h11);
    drive(1'b0, 64'd0);
    tick();
    check("bp_full_hold", ex.ready, 1'b0);
    mem.ready = 1'b1;
    tick();
    check("bp_then_b", mem.alu_result, 64'h22);
    check("bp_ready_back", ex.ready, 1'b1);
    tick();
    check("bp_drained", mem.valid, 1'b0);

    // Flush while FULL, with a pending payload C
    mem.ready = 1'b0;
    drive(1'b1, 64'h44);
    tick();
    drive(1'b1, 64'h55);
    tick();
    drive(1'b1, 64'h33);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 64'd0);
    check("flush_full_valid", mem.valid, 1'b0);
    check("flush_full_ready", ex.ready, 1'b1);
    mem.ready = 1'b1;
    repeat (3) tick();
    check("flush_no_c", mem.valid, 1'b0);

    // Flush while BUSY discards the same-cycle accepted payload
    mem.ready = 1'b0;
    drive(1'b1, 64'h66);
    tick();
    drive(1'b1, 64'h77);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 64'd0);
    check("flush_busy_valid", mem.valid, 1'b0);
    check("flush_busy_ready", ex.ready, 1'b1);
    tick();
    check("flush_busy_discard", mem.valid, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), {$urandom, $urandom});
      mem.ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      tick();
    end
    flush = 1'b0;
    drive(1'b0, 64'd0);
    mem.ready = 1'b1;
    repeat (10) tick();
    check("drain_queue_empty", 32'(q.size()), 32'd0);
    check("drain_mem_valid", mem.valid, 1'b0);

    // Stall counter, 32-bit and saturating 4-bit
    #1 sys_rst = 1'b0;
    #1 sys_rst = 1'b1;
    check("stall_after_rst", stall_cnt, 32'd0);
    mem.ready = 1'b0;
    drive(1'b1, 64'h99);
    tick();
    drive(1'b0, 64'd0);
    repeat (10) tick();
    check("stall_10", stall_cnt, 32'd10);
    check("stall_10_w4", stall_cnt4, 4'd10);
    repeat (10) tick();
    check("stall_20", stall_cnt, 32'd20);
    check("stall_20_w4_sat", stall_cnt4, 4'd15);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("stall_flush_kept", stall_cnt, 32'd21);
    check("stall_flush_w4", stall_cnt4, 4'd15);

    // Asynchronous reset while FULL
    drive(1'b1, 64'hAA);
    tick();
    drive(1'b1, 64'hBB);
    tick();
    drive(1'b0, 64'd0);
    check("ar_full", ex.ready, 1'b0);
    #2 sys_rst = 1'b0;
    #1;
    check("ar_mem_valid", mem.valid, 1'b0);
    check("ar_ex_ready", ex.ready, 1'b1);
    check("ar_alu", mem.alu_result, 64'd0);
    check("ar_stall", stall_cnt, 32'd0);
    @(posedge sys_clk);
    #3 sys_rst = 1'b1;
    mem.ready = 1'b1;
    repeat (3) tick();
    check("ar_nothing_survives", mem.valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
